// File: rtl/cvp14_pkg.sv
// Shared definitions for the vector core: opcodes, lane geometry
// and the execute-stage state encoding.
package cvp14_pkg;

    localparam int LANE_W    = 16;
    localparam int NUM_LANES = 16;
    localparam int RES_W     = LANE_W * NUM_LANES;

    localparam logic [3:0] FT_VADD = 4'd0;
    localparam logic [3:0] FT_VDOT = 4'd1;
    localparam logic [3:0] FT_SMUL = 4'd2;
    localparam logic [3:0] FT_SST  = 4'd3;
    localparam logic [3:0] FT_VLD  = 4'd4;
    localparam logic [3:0] FT_VST  = 4'd5;
    localparam logic [3:0] FT_SLL  = 4'd6;
    localparam logic [3:0] FT_SLH  = 4'd7;
    localparam logic [3:0] FT_J    = 4'd8;
    localparam logic [3:0] FT_NOP  = 4'd15;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic logic is_vector(input logic [3:0] ft);
        return (ft == FT_VADD) || (ft == FT_VDOT);
    endfunction

endpackage

// File: rtl/vector_exec_unit_lane_alu.sv
// One 16-bit lane datapath: wrapping add and low-half multiply.
module lane_alu
    import cvp14_pkg::*;
(
    input  logic [LANE_W-1:0] a,
    input  logic [LANE_W-1:0] b,
    output logic [LANE_W-1:0] sum,
    output logic [LANE_W-1:0] prod
);

    assign sum  = a + b;
    assign prod = a * b;

endmodule

// File: rtl/vector_exec_unit.sv
// Execute stage: iterative VADD/VDOT over lane groups, single-cycle
// scalar/address ops, start/busy/done handshake.
module vector_exec_unit
    import cvp14_pkg::*;
#(
    parameter int LANES_PER_CYCLE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       functype,
    input  logic [RES_W-1:0] op1,
    input  logic [RES_W-1:0] op2,
    output logic             busy,
    output logic             done,
    output logic [RES_W-1:0] result
);

    localparam int IDX_W    = $clog2(NUM_LANES);
    localparam int LANE_SH  = $clog2(LANE_W);
    localparam int LAST_IDX = NUM_LANES - LANES_PER_CYCLE;

    state_e             state_q, state_d;
    logic [3:0]         ft_q, ft_d;
    logic [RES_W-1:0]   op1_q, op1_d;
    logic [RES_W-1:0]   op2_q, op2_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [LANE_W-1:0]  acc_q, acc_d;
    logic [RES_W-1:0]   result_q, result_d;

    logic [LANE_W-1:0]  op1_lane [NUM_LANES];
    logic [LANE_W-1:0]  op2_lane [NUM_LANES];
    logic [IDX_W-1:0]   grp_idx  [LANES_PER_CYCLE];
    logic [LANE_W-1:0]  alu_sum  [LANES_PER_CYCLE];
    logic [LANE_W-1:0]  alu_prod [LANES_PER_CYCLE];

    logic               accept;
    logic               last_grp;
    logic [LANE_W-1:0]  dot_sum;
    logic [LANE_W-1:0]  scalar_res;

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane_view
        assign op1_lane[l] = op1_q[l*LANE_W +: LANE_W];
        assign op2_lane[l] = op2_q[l*LANE_W +: LANE_W];
    end

    for (genvar g = 0; g < LANES_PER_CYCLE; g++) begin : g_alu
        assign grp_idx[g] = idx_q + IDX_W'(g);
        lane_alu u_lane_alu (
            .a    (op1_lane[grp_idx[g]]),
            .b    (op2_lane[grp_idx[g]]),
            .sum  (alu_sum[g]),
            .prod (alu_prod[g])
        );
    end

    assign accept   = start && (state_q != ST_RUN);
    assign last_grp = (idx_q == IDX_W'(LAST_IDX));

    always_comb begin
        dot_sum = acc_q;
        for (int g = 0; g < LANES_PER_CYCLE; g++) begin
            dot_sum = dot_sum + alu_prod[g];
        end
    end

    // Scalar ops only run with idx at 0, so ALU slot 0 sees lane 0.
    always_comb begin
        scalar_res = '0;
        unique case (1'b1)
            (ft_q == FT_SMUL): scalar_res = alu_prod[0];
            (ft_q == FT_VLD) || (ft_q == FT_VST) || (ft_q == FT_J):
                scalar_res = alu_sum[0];
            (ft_q == FT_SLL): scalar_res = {op1_q[15:8], op2_q[7:0]};
            (ft_q == FT_SLH): scalar_res = {op2_q[7:0], op1_q[7:0]};
            default: scalar_res = '0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        ft_d     = ft_q;
        op1_d    = op1_q;
        op2_d    = op2_q;
        idx_d    = idx_q;
        acc_d    = acc_q;
        result_d = result_q;

        case (state_q)
            ST_RUN: begin
                if (is_vector(ft_q)) begin
                    if (ft_q == FT_VADD) begin
                        for (int g = 0; g < LANES_PER_CYCLE; g++) begin
                            result_d[{grp_idx[g], LANE_SH'(0)} +: LANE_W] =
                                alu_sum[g];
                        end
                    end else begin
                        acc_d = dot_sum;
                    end
                    idx_d = idx_q + IDX_W'(LANES_PER_CYCLE);
                    if (last_grp) begin
                        state_d = ST_DONE;
                        if (ft_q == FT_VDOT) begin
                            result_d = {{(RES_W-LANE_W){1'b0}}, dot_sum};
                        end
                    end
                end else begin
                    result_d = {{(RES_W-LANE_W){1'b0}}, scalar_res};
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (accept) begin
            state_d = ST_RUN;
            ft_d    = functype;
            op1_d   = op1;
            op2_d   = op2;
            idx_d   = '0;
            acc_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            ft_q     <= FT_NOP;
            op1_q    <= '0;
            op2_q    <= '0;
            idx_q    <= '0;
            acc_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            ft_q     <= ft_d;
            op1_q    <= op1_d;
            op2_q    <= op2_d;
            idx_q    <= idx_d;
            acc_q    <= acc_d;
            result_q <= result_d;
        end
    end

    assign busy   = (state_q == ST_RUN);
    assign done   = (state_q == ST_DONE);
    assign result = result_q;

endmodule

// File: tb/tb_vector_exec_unit.sv
// Self-checking bench for vector_exec_unit against a lane-level model.
module tb_vector_exec_unit;

    logic         clk;
    logic         rst;
    logic         start;
    logic [3:0]   functype;
    logic [255:0] op1;
    logic [255:0] op2;
    logic         busy;
    logic         done;
    logic [255:0] result;

    int n_checks;
    int n_fail;

    vector_exec_unit #(.LANES_PER_CYCLE(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .functype (functype),
        .op1      (op1),
        .op2      (op2),
        .busy     (busy),
        .done     (done),
        .result   (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [255:0] fill(input logic [15:0] v);
        logic [255:0] r;
        for (int i = 0; i < 16; i++) r[16*i +: 16] = v;
        return r;
    endfunction

    function automatic logic [255:0] model(input logic [3:0] ft,
                                           input logic [255:0] a,
                                           input logic [255:0] b);
        logic [255:0] r;
        logic [15:0]  acc;
        logic [15:0]  p;
        r = '0;
        case (ft)
            4'd0: for (int i = 0; i < 16; i++)
                r[16*i +: 16] = a[16*i +: 16] + b[16*i +: 16];
            4'd1: begin
                acc = 0;
                for (int i = 0; i < 16; i++) begin
                    p   = a[16*i +: 16] * b[16*i +: 16];
                    acc = acc + p;
                end
                r[15:0] = acc;
            end
            4'd2: r[15:0] = a[15:0] * b[15:0];
            4'd4, 4'd5, 4'd8: r[15:0] = a[15:0] + b[15:0];
            4'd6: r[15:0] = {a[15:8], b[7:0]};
            4'd7: r[15:0] = {b[7:0], a[7:0]};
            default: r = '0;
        endcase
        return r;
    endfunction

    task automatic run_op(input logic [3:0] ft, input logic [255:0] a,
                          input logic [255:0] b, input string nm);
        logic [255:0] exp;
        int n;
        exp = model(ft, a, b);
        n = (ft <= 4'd1) ? 4 : 1;
        @(negedge clk);
        functype = ft; op1 = a; op2 = b; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        functype = 4'($urandom); op1 = rand256(); op2 = rand256();
        for (int k = 1; k <= n + 1; k++) begin
            n_checks++;
            if (busy !== (k <= n)) begin
                n_fail++;
                $display("FAIL %s busy cyc%0d got %b want %b",
                         nm, k, busy, (k <= n));
            end
            n_checks++;
            if (done !== (k == n + 1)) begin
                n_fail++;
                $display("FAIL %s done cyc%0d got %b want %b",
                         nm, k, done, (k == n + 1));
            end
            if (k == n + 1) begin
                n_checks++;
                if (result !== exp) begin
                    n_fail++;
                    $display("FAIL %s result got %h want %h", nm, result, exp);
                end
            end
            @(negedge clk);
        end
        n_checks++;
        if (done !== 1'b0 || result !== exp) begin
            n_fail++;
            $display("FAIL %s hold done=%b result got %h want %h",
                     nm, done, result, exp);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; functype = 4'd0;
        op1 = rand256(); op2 = rand256();
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== '0) begin
            n_fail++;
            $display("FAIL reset_state busy=%b done=%b result=%h want 0 0 0",
                     busy, done, result);
        end
        start = 1'b0; rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle busy got %b want 0", busy);
        end
    endtask

    task automatic test_directed();
        logic [255:0] ramp;
        for (int i = 0; i < 16; i++) ramp[16*i +: 16] = 16'(i);
        run_op(4'd0, fill(16'h0001), ramp, "vadd_ramp");
        run_op(4'd1, fill(16'd2), fill(16'd3), "vdot_96");
        run_op(4'd1, fill(16'h0100), fill(16'h0100), "vdot_wrap0");
        run_op(4'd4, 256'h0010, 256'hFFFE, "vld_neg");
        run_op(4'd8, 256'hFFFF, 256'h0002, "j_wrap");
        run_op(4'd6, 256'hABCD, 256'h12, "sll");
        run_op(4'd7, 256'hABCD, 256'h12, "slh");
        run_op(4'd2, 256'h0100, 256'h0100, "smul_wrap");
        run_op(4'd3, rand256(), rand256(), "sst");
        run_op(4'd15, rand256(), rand256(), "nop");
    endtask

    task automatic test_random();
        logic [3:0] ft;
        for (int i = 0; i < 24; i++) begin
            ft = 4'($urandom_range(0, 15));
            run_op(ft, rand256(), rand256(), $sformatf("rand%0d_ft%0d", i, ft));
        end
    endtask

    task automatic test_back_to_back();
        logic [255:0] a, b, x, y, exp_v, exp_s;
        a = rand256(); b = rand256();
        x = rand256(); y = rand256();
        exp_v = model(4'd0, a, b);
        exp_s = model(4'd2, x, y);
        @(negedge clk);
        functype = 4'd0; op1 = a; op2 = b; start = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            op1 = rand256(); op2 = rand256();
            n_checks++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b_run cyc%0d busy=%b done=%b want 1 0",
                         k, busy, done);
            end
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b1 || result !== exp_v) begin
            n_fail++;
            $display("FAIL b2b_vadd done=%b result got %h want %h",
                     done, result, exp_v);
        end
        functype = 4'd2; op1 = x; op2 = y;
        @(negedge clk);
        start = 1'b0; op1 = rand256(); op2 = rand256();
        n_checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_issue busy=%b done=%b want 1 0", busy, done);
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b1 || result !== exp_s) begin
            n_fail++;
            $display("FAIL b2b_smul done=%b result got %h want %h",
                     done, result, exp_s);
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_single busy=%b done=%b want 0 0", busy, done);
        end
    endtask

    task automatic test_reset_mid_run();
        int seen;
        @(negedge clk);
        functype = 4'd1; op1 = fill(16'd2); op2 = fill(16'd3); start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== '0) begin
            n_fail++;
            $display("FAIL rst_mid busy=%b done=%b result=%h want 0 0 0",
                     busy, done, result);
        end
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        n_checks++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL rst_no_done activity got %0d want 0", seen);
        end
        run_op(4'd0, rand256(), rand256(), "vadd_after_rst");
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b0; start = 1'b0; functype = '0; op1 = '0; op2 = '0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_random();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vector_exec_unit.md
Name: vector_exec_unit

Overview:
- Execute stage directly downstream of the operand picker. Consumes the picker's functype/op1/op2 and produces a 256-bit result for writeback or the memory stage.
- Vector ops (VADD, VDOT) run iteratively over 16 lanes of 16 bits, LANES_PER_CYCLE lanes per cycle.
- Scalar and address ops (SMUL, VLD, VST, SLL, SLH, J) complete in one compute cycle.
- Uses a start/busy/done handshake with the pipeline controller.

Parameters:
- NUM_LANES, 16, lanes per vector register; fixed, 256 = NUM_LANES*LANE_W.
- LANE_W, 16, lane width in bits.
- LANES_PER_CYCLE, 4, lanes processed per RUN cycle; legal values are 1, 2, 4, 8, 16.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request to begin an operation; sampled only when the unit can accept.
- functype  input  4  opcode: VADD=0, VDOT=1, SMUL=2, SST=3, VLD=4, VST=5, SLL=6, SLH=7, J=8, NOP=15.
- op1  input  256  operand 1 from the picker.
- op2  input  256  operand 2 from the picker.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse; result is valid from that cycle on.
- result  output  256  held until the next accepted start or reset.

Behaviour:
- States:
  - IDLE, RUN, DONE.
- Reset:
  - Synchronous: next edge with rst=1 forces state=IDLE, busy=0, done=0, result=0, accumulator=0, lane index=0.
  - Reset overrides start.
  - Reset during RUN abandons the operation; no done pulse follows.
- Accept:
  - start=1 in IDLE or DONE is accepted at that edge.
  - On accept: functype/op1/op2 are latched into internal registers, lane index=0, accumulator=0, next state=RUN.
  - start while in RUN is ignored. The controller must hold its request until it can be accepted; it is not queued.
- RUN length:
  - N cycles, where N = NUM_LANES/LANES_PER_CYCLE for VADD/VDOT and N = 1 for all other functypes.
  - Each cycle processes lanes idx..idx+LANES_PER_CYCLE-1; idx then advances by LANES_PER_CYCLE.
  - After the last group, next state=DONE.
- Latency:
  - Start accepted at edge of cycle 0. busy=1 in cycles 1..N. done=1 in cycle N+1.
  - Default VADD: done in cycle 5. Scalar ops: done in cycle 2.
- DONE lasts exactly one cycle. It then returns to IDLE, unless start=1 in that cycle, in which case it goes straight to RUN (back-to-back issue, no bubble).
- Arithmetic (all modulo 2^16, two's complement, no saturation or flags):
  - VADD: result lane i = op1[16i+:16] + op2[16i+:16]. Lanes are written into the result register as each group completes.
  - VDOT: acc += sum over the group of op1 lane * op2 lane, keeping the low 16 bits of each product. Final result = {240'd0, acc}.
  - SMUL: {240'd0, low16(op1[15:0]*op2[15:0])}.
  - VLD, VST, J: {240'd0, op1[15:0]+op2[15:0]}. op2 is already sign-extended by the picker; the 16-bit wrap gives the address or target.
  - SLL: {240'd0, op1[15:8], op2[7:0]}.
  - SLH: {240'd0, op2[7:0], op1[7:0]}.
  - SST, NOP, undefined codes: result=0, still a 1-cycle RUN and a done pulse.
- Intermediate VADD lanes are visible on result during RUN and are not valid until done. Consumers must sample only on done.
- Latched operands are used throughout RUN; changes on op1/op2/functype after accept have no effect.

Decomposition:
- Shared package cvp14_pkg holds:
  - functype localparams, shared with the operand picker and decoder;
  - LANE_W, NUM_LANES;
  - state encoding IDLE/RUN/DONE.
- One natural sub-module, lane_alu: a combinational 16-bit add plus 16x16 multiply keeping the low 16 bits. It is instantiated LANES_PER_CYCLE times, selected by lane index.
- FSM, lane counter, accumulator and result register live in vector_exec_unit.

Test Plan:
- VADD, all op1 lanes=16'h0001, op2 lane i=i -> done at cycle 5 (LPC=4); result lane i = i+1; busy high for cycles 1-4 only.
- VDOT, op1 lanes=2, op2 lanes=3 -> result=16'd96; then op1 lanes=16'h0100, op2 lanes=16'h0100 -> each product's low 16 bits are 0, result=0.
- VLD with op1=16'h0010, op2=16'hFFFE (offset -2) -> result=16'h000E, done at cycle 2. J with op1=16'hFFFF, op2=16'h0002 -> 16'h0001 (wrap).
- SLL with op1=16'hABCD, op2=8'h12 -> 16'hAB12. SLH with same operands -> 16'h12CD. SMUL 16'h0100*16'h0100 -> 0.
- Back-to-back and ignore: start held during a VADD RUN is ignored; start during DONE issues SMUL with no idle cycle; exactly one done pulse per accepted op.
- Reset: rst=1 in cycle 2 of a VDOT -> next cycle state IDLE, busy=0, result=0, and no done pulse; a new VADD then completes normally.
